// File: rtl/seg_scan_pkg.sv
// Shared types, segment table and scan helpers for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Nearest set bit strictly above cur, wrapping through 0; cur itself only if it is the sole set bit.
  function automatic int unsigned next_set_bit(input logic [15:0] mask,
                                               input int unsigned cur,
                                               input int unsigned width);
    int unsigned pos;
    next_set_bit = cur;
    for (int unsigned k = width; k >= 1; k--) begin
      pos = cur + k;
      if (pos >= width) pos = pos - width;
      if (mask[pos[3:0]]) next_set_bit = pos;
    end
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to seven-segment decoder (active-high segments).
module hex_to_7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[val];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-slot anti-ghosting blank.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int DIV        = 100000,
  parameter int BLANK_CYC  = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_DIGITS-1:0]         digit_mask,
  input  logic [4*N_DIGITS-1:0]       val_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  output logic [N_DIGITS-1:0]         digit_sel,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [$clog2(N_DIGITS)-1:0] scan_idx,
  output logic                        frame_tick
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0]    LAST_C  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_C = CNT_W'(BLANK_CYC);
  localparam logic [N_DIGITS-1:0] ONE     = N_DIGITS'(1);
  localparam state_t SLOT_START = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 run;
  logic                 show;
  logic                 lz_blank;
  logic [3:0]           cur_val;
  logic                 cur_dp;
  logic [6:0]           dec_seg;
  logic [N_DIGITS-1:0]  sel_r;
  logic [6:0]           seg_r;
  logic                 dp_r;

  assign run     = en && (digit_mask != '0);
  assign cnt_inc = cnt + 1'b1;
  assign nxt_idx = IDX_W'(next_set_bit(16'(digit_mask), 32'(scan_idx), N_DIGITS));
  assign cur_val = val_in[{scan_idx, 2'b00} +: 4];
  assign cur_dp  = dp_in[scan_idx];
  // Live mask and enable gate the drive so a cleared digit goes dark on the next cycle.
  assign show    = run && (state == S_SHOW) && digit_mask[scan_idx];

  hex_to_7seg u_dec (
    .val (cur_val),
    .seg (dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [N_DIGITS-1:0] nz;
  logic [N_DIGITS-1:0] nz_above;

  always_comb begin
    nz = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      nz[i] = digit_mask[i] && (val_in[4*i +: 4] != 4'h0);
  end

  always_comb begin
    nz_above = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      for (int unsigned j = i + 1; j < N_DIGITS; j++)
        nz_above[i] = nz_above[i] | nz[j];
  end

  assign lz_blank = (scan_idx != '0) && (cur_val == 4'h0) && !cur_dp && !nz_above[scan_idx];
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      scan_idx   <= '0;
      frame_tick <= 1'b0;
      sel_r      <= '0;
      seg_r      <= SEG_OFF;
      dp_r       <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      sel_r      <= show ? (ONE << scan_idx) : '0;
      seg_r      <= (show && !lz_blank) ? dec_seg : SEG_OFF;
      dp_r       <= show && cur_dp;
      if (!run) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (state == S_IDLE) begin
        state <= SLOT_START;
        cnt   <= '0;
        // Realign to an enabled digit when the held index is masked off.
        if (!digit_mask[scan_idx]) begin
          scan_idx   <= nxt_idx;
          frame_tick <= (nxt_idx <= scan_idx);
        end
      end else if (cnt == LAST_C) begin
        state      <= SLOT_START;
        cnt        <= '0;
        scan_idx   <= nxt_idx;
        frame_tick <= (nxt_idx <= scan_idx);
      end else begin
        state <= (cnt_inc < BLANK_C) ? S_BLANK : S_SHOW;
        cnt   <= cnt_inc;
      end
    end
  end

  assign digit_sel = sel_r ^ {N_DIGITS{ACTIVE_LOW}};
  assign seg       = seg_r ^ {7{ACTIVE_LOW}};
  assign dp        = dp_r ^ ACTIVE_LOW;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: an active-high and an active-low instance share all inputs.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  mask;
  logic [15:0] val;
  logic [3:0]  dpi;

  logic [3:0]  sel_a, sel_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [1:0]  idx_a, idx_b;
  logic        ft_a, ft_b;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.N_DIGITS(4), .DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask), .val_in(val), .dp_in(dpi),
    .digit_sel(sel_a), .seg(seg_a), .dp(dp_a), .scan_idx(idx_a), .frame_tick(ft_a)
  );

  seg_scan_ctrl #(.N_DIGITS(4), .DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask), .val_in(val), .dp_in(dpi),
    .digit_sel(sel_b), .seg(seg_b), .dp(dp_b), .scan_idx(idx_b), .frame_tick(ft_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expectations are given in active-high terms; the active-low instance must show their inverse.
  task automatic check(input string tag, input logic [3:0] es, input logic [6:0] eg,
                       input logic ed, input logic [1:0] ei, input logic ef);
    logic [3:0] ns;
    logic [6:0] ng;
    logic       nd;
    string      t;
    ns = ~es;
    ng = ~eg;
    nd = ~ed;
    t  = $sformatf("%s@%0d", tag, cyc);
    chk({t, ".sel"},   32'(sel_a), 32'(es));
    chk({t, ".seg"},   32'(seg_a), 32'(eg));
    chk({t, ".dp"},    32'(dp_a),  32'(ed));
    chk({t, ".idx"},   32'(idx_a), 32'(ei));
    chk({t, ".ft"},    32'(ft_a),  32'(ef));
    chk({t, ".sel_n"}, 32'(sel_b), 32'(ns));
    chk({t, ".seg_n"}, 32'(seg_b), 32'(ng));
    chk({t, ".dp_n"},  32'(dp_b),  32'(nd));
    chk({t, ".idx_n"}, 32'(idx_b), 32'(ei));
    chk({t, ".ft_n"},  32'(ft_b),  32'(ef));
  endtask

  initial begin
    int         m;
    int         d;
    logic       act;
    logic [3:0] es;
    logic [6:0] eg;
    logic       ed;
    logic [1:0] ei;
    logic       ef;
    logic [6:0] segs [4];
    logic [6:0] lz;

    // Segment patterns of 16'h1234 by digit position: 4, 3, 2, 1.
    segs = '{7'h66, 7'h4F, 7'h5B, 7'h06};

    rst = 1'b1; en = 1'b1; mask = 4'hF; val = 16'h1234; dpi = 4'b0100;
    tick();
    tick();
    check("reset", 4'h0, 7'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // Full mask: slot = 2 blank + 6 shown (output lags one cycle), frame of 32.
    for (int c = 1; c <= 40; c++) begin
      tick();
      m   = c - 4;
      act = (m >= 0) && (m % 8 < 6);
      d   = act ? (m / 8) % 4 : 0;
      es  = act ? 4'(1 << d) : 4'h0;
      eg  = act ? segs[d] : 7'h00;
      ed  = act && dpi[d];
      ei  = 2'(((c - 1) / 8) % 4);
      ef  = (c == 33);
      check("full", es, eg, ed, ei, ef);
    end

    // Sparse mask 1010: digits 1 and 3 alternate, frame of 16.
    mask = 4'b1010;
    do_reset();
    for (int c = 1; c <= 34; c++) begin
      tick();
      m   = c - 4;
      act = (m >= 0) && (m % 8 < 6);
      d   = ((m / 8) % 2 != 0) ? 3 : 1;
      es  = act ? 4'(1 << d) : 4'h0;
      eg  = act ? segs[d] : 7'h00;
      ed  = 1'b0;
      ei  = (((c - 1) / 8) % 2 != 0) ? 2'd3 : 2'd1;
      ef  = (c == 17) || (c == 33);
      check("sparse", es, eg, ed, ei, ef);
    end

    // Mid-slot clear of the current digit, then en dropped for 5 cycles.
    mask = 4'hF; dpi = 4'b0000;
    do_reset();
    run_to(5);
    check("clr_before", 4'b0001, 7'h66, 1'b0, 2'd0, 1'b0);
    mask = 4'b1110;
    tick();
    check("clr_off", 4'h0, 7'h00, 1'b0, 2'd0, 1'b0);
    run_to(9);
    check("clr_wrap", 4'h0, 7'h00, 1'b0, 2'd1, 1'b0);
    run_to(12);
    check("clr_next", 4'b0010, 7'h4F, 1'b0, 2'd1, 1'b0);
    run_to(13);
    check("en_before", 4'b0010, 7'h4F, 1'b0, 2'd1, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_low", 4'h0, 7'h00, 1'b0, 2'd1, 1'b0);
    end
    en = 1'b1;
    run_to(21);
    check("en_blank", 4'h0, 7'h00, 1'b0, 2'd1, 1'b0);
    tick();
    check("en_show", 4'b0010, 7'h4F, 1'b0, 2'd1, 1'b0);
    run_to(27);
    check("en_wrap", 4'b0010, 7'h4F, 1'b0, 2'd2, 1'b0);
    tick();
    check("en_wrap_off", 4'h0, 7'h00, 1'b0, 2'd2, 1'b0);
    run_to(30);
    check("en_next", 4'b0100, 7'h5B, 1'b0, 2'd2, 1'b0);

    // Digit 0 = 0xF with its decimal point, seen through both polarities.
    mask = 4'hF; val = 16'h123F; dpi = 4'b0001;
    do_reset();
    run_to(3);
    check("hexF_blank", 4'h0, 7'h00, 1'b0, 2'd0, 1'b0);
    tick();
    check("hexF_show", 4'b0001, 7'h71, 1'b1, 2'd0, 1'b0);

    // Leading zeros on 16'h0050.
    val = 16'h0050; dpi = 4'b0000;
`ifdef SEG_SCAN_LZB_EN
    lz = 7'h00;
`else
    lz = 7'h3F;
`endif
    do_reset();
    run_to(4);
    check("lz_d0", 4'b0001, 7'h3F, 1'b0, 2'd0, 1'b0);
    run_to(12);
    check("lz_d1", 4'b0010, 7'h6D, 1'b0, 2'd1, 1'b0);
    run_to(20);
    check("lz_d2", 4'b0100, lz, 1'b0, 2'd2, 1'b0);
    run_to(28);
    check("lz_d3", 4'b1000, lz, 1'b0, 2'd3, 1'b0);

    // Reset between clock edges must clear outputs at once.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 4'h0, 7'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller that time-shares one segment bus across N_DIGITS common-anode or common-cathode digits. It takes packed 4-bit digit values and decimal points, steps through the enabled digits at a programmable slot rate with an anti-ghosting blank interval, and drives one-hot digit selects plus decoded segments. It sits between the counter/datapath logic and the board display pins.

## Interface
- N_DIGITS, 8: number of digits scanned; legal 2..16.
- DIV, 100000: clk cycles per digit slot; legal ≥ 2.
- BLANK_CYC, 1000: cycles at the start of each slot with all digits off; legal 0..DIV-1.
- ACTIVE_LOW, 0: 1 inverts digit_sel, seg and dp at the pins.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 blanks the display and freezes the scan.
- digit_mask  in  N_DIGITS  1 = digit participates in the scan.
- val_in  in  4*N_DIGITS  digit i value in bits [4i+3:4i], 0x0..0xF.
- dp_in  in  N_DIGITS  decimal point per digit.
- digit_sel  out  N_DIGITS  one-hot digit drive, all-inactive when blanked.
- seg  out  7  segments, bit 0 = a … bit 6 = g.
- dp  out  1  decimal point of the displayed digit.
- scan_idx  out  clog2(N_DIGITS)  index of the current slot's digit.
- frame_tick  out  1  one-cycle pulse when the scan wraps to the first enabled digit.

## Operation
- FSM: IDLE, BLANK, SHOW.
  - IDLE: en=0 or digit_mask==0. slot counter cnt=0, outputs inactive, scan_idx held. Go to BLANK when en=1 and mask≠0.
  - BLANK: cnt<BLANK_CYC. digit_sel inactive, seg/dp inactive. Go to SHOW at cnt==BLANK_CYC. If BLANK_CYC=0, skip straight to SHOW.
  - SHOW: drive digit_sel[scan_idx], seg=decode(val_in[scan_idx]), dp=dp_in[scan_idx].
  - At cnt==DIV-1: cnt←0, scan_idx←next set bit of digit_mask above scan_idx (wrapping from the top to the lowest set bit), then go to BLANK.
- Any state: en=0 or mask==0 → IDLE next cycle.
- Next-digit search uses the mask sampled at the slot boundary. If the current digit is cleared mid-slot, outputs go inactive from the next cycle, and the scan advances normally at the slot end.
- Single enabled digit: scan_idx stays fixed, BLANK still occurs every slot, and frame_tick fires every slot.
- frame_tick: high for the single cycle in which scan_idx is loaded with a value ≤ its previous value.
- Decode is hex: 0–9, then A, b, C, d, E, F for 0xA–0xF.
- Polarity: internal logic is active-high. ACTIVE_LOW XORs only the three pin outputs.

## Timing
- All outputs are registered. A change on val_in or dp_in appears on seg/dp 1 cycle later.
- digit_sel goes inactive in the cycle after cnt wraps. It goes active in the cycle after cnt reaches BLANK_CYC.
- Slot length is exactly DIV cycles. Frame length is DIV × popcount(digit_mask).
- Reset values: digit_sel, seg and dp at their inactive levels (all-0, or all-1 when ACTIVE_LOW=1), scan_idx=0, frame_tick=0, cnt=0, state IDLE.
- Reset mid-slot takes effect asynchronously. The first slot after release starts at the lowest enabled digit if digit 0 is masked, otherwise at digit 0.

## Configuration
- SEG_SCAN_LZB_EN: leading-zero blanking.
  - Defined: any digit above the most significant nonzero enabled digit whose value is 0 and whose dp_in is 0 shows seg=inactive. Digit 0 is never blanked. digit_sel and timing are unchanged.
  - Undefined: every enabled digit always shows its decoded value. No extra logic is built.

## Structure
- Package seg_scan_pkg holds:
  - the FSM state enum;
  - a 16-entry 7-bit hex segment constant table;
  - SEG_OFF constant;
  - a next_set_bit function parameterised on width.
- Sub-module hex_to_7seg: combinational 4-bit to 7-bit decoder using the package table, instantiated once on the muxed digit value.

## Test plan
- Reset release, N_DIGITS=4, DIV=8, BLANK_CYC=2, mask=4'hF, val=16'h1234 → digit_sel 0001/0010/0100/1000 each active 6 of every 8 cycles; seg shows 4,3,2,1 (0x66, 0x4F, 0x5B, 0x06); frame_tick every 32 cycles.
- mask=4'b1010 → scan_idx alternates 1,3; digits 0 and 2 never driven; frame length 16 cycles.
- Mid-slot clear of the current digit's mask bit → digit_sel inactive next cycle; the next slot goes to the next enabled digit.
- en dropped mid-SHOW for 5 cycles → outputs inactive, scan_idx held; the slot restarts from cnt=0 with BLANK.
- ACTIVE_LOW=1, val 0xF on digit 0 → digit_sel=4'b1110, seg=~7'h71 during SHOW.
- With SEG_SCAN_LZB_EN defined, val=16'h0050 → digits 3 and 2 segments off, digits 1 and 0 show 5 and 0; without it, all four digits show 0,0,5,0.
